load_store_unit: RTL and testbench

//   Memory stage directly downstream of the ALU: takes the ALU result as the effective address
//   and performs one load or store per request against a single-ported data memory through a
//   req/ack handshake. Generates byte enables and store-data lane replication, and extracts,

---
 rtl/load_store_unit.sv | 167 ++++++++++++++++
 tb/tb_load_store_unit.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// load_store_unit: memory stage between the ALU and writeback.
// Issues one load or store per request over a req/ack memory handshake.
// It builds byte enables and replicates store data across lanes. It aligns
// and sign- or zero-extends load data, and bounds every access with a timeout.
// Optional feature macro: MISALIGN_TRAP_EN. When it is defined, a misaligned
// request is answered with an error and no memory access is made. When it is
// undefined, a misaligned request is silently aligned.
module load_store_unit #(
  parameter int WORD_SIZE      = 32,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 req_valid,
  output logic                 req_ready,
  input  logic                 req_we,
  input  logic [1:0]           req_size,
  input  logic                 req_unsigned,
  input  logic [WORD_SIZE-1:0] req_addr,
  input  logic [WORD_SIZE-1:0] req_wdata,
  output logic                 rsp_valid,
  output logic [WORD_SIZE-1:0] rsp_rdata,
  output logic                 rsp_err,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [WORD_SIZE-1:0] mem_addr,
  output logic [WORD_SIZE-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  input  logic                 mem_ack,
  input  logic [WORD_SIZE-1:0] mem_rdata
);

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  // Last counter value at which a missing ack is still tolerated.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t               state;
  logic [7:0]           tmo_cnt;
  logic [1:0]           size_q;
  logic                 uns_q;
  logic [1:0]           off_q;

  logic [1:0]           req_off;
  logic [3:0]           be_c;
  logic [WORD_SIZE-1:0] wdata_c;
  logic                 misalign;
  logic [1:0]           ld_off;
  logic [WORD_SIZE-1:0] shifted;
  logic [WORD_SIZE-1:0] load_data;

  assign req_ready = (state == IDLE);

  // Decode byte enables, store lane replication and misalignment from the live request.
  always_comb begin
    // NOTE: every output gets a default first, so no path leaves a value unassigned and no latch is inferred.
    req_off  = req_addr[1:0];
    be_c     = 4'b1111;
    wdata_c  = req_wdata;
    misalign = 1'b0;
    case (req_size)
      2'b00: begin
        be_c    = 4'b0001 << req_off;
        wdata_c = {4{req_wdata[7:0]}};
      end
      2'b01: begin
        be_c     = req_off[1] ? 4'b1100 : 4'b0011;
        wdata_c  = {2{req_wdata[15:0]}};
        misalign = req_off[0];
      end
      default: misalign = (req_off != 2'b00);
    endcase
    if (!req_we) be_c = 4'b0000;
  end

  // Select the addressed lane of the returned word and extend it to full width.
  always_comb begin
    case (size_q)
      2'b00:   ld_off = off_q;
      2'b01:   ld_off = {off_q[1], 1'b0};
      default: ld_off = 2'b00;
    endcase
    shifted = mem_rdata >> {ld_off, 3'b000};
    case (size_q)
      2'b00:   load_data = {{24{~uns_q & shifted[7]}}, shifted[7:0]};
      2'b01:   load_data = {{16{~uns_q & shifted[15]}}, shifted[15:0]};
      default: load_data = shifted;
    endcase
    if (mem_we) load_data = '0;
  end

  // Request/response FSM with registered memory and response outputs.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments, so every register samples pre-edge values.
    if (rst) begin
      state     <= IDLE;
      tmo_cnt   <= '0;
      size_q    <= '0;
      uns_q     <= 1'b0;
      off_q     <= '0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      rsp_valid <= 1'b0;
      rsp_err   <= 1'b0;
      rsp_rdata <= '0;
    end else begin
      case (state)
        IDLE: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          if (req_valid) begin
            size_q <= req_size;
            uns_q  <= req_unsigned;
            off_q  <= req_addr[1:0];
            if (TRAP_EN && misalign) begin
              rsp_valid <= 1'b1;
              rsp_err   <= 1'b1;
              state     <= RESP;
            end else begin
              mem_req   <= 1'b1;
              mem_we    <= req_we;
              mem_addr  <= {req_addr[WORD_SIZE-1:2], 2'b00};
              mem_wdata <= wdata_c;
              mem_be    <= be_c;
              tmo_cnt   <= '0;
              state     <= ACCESS;
            end
          end
        end
        ACCESS: begin
          // An ack takes priority over a timeout that expires in the same cycle.
          if (mem_ack || tmo_cnt == TMO_LAST) begin
            mem_req   <= 1'b0;
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            rsp_valid <= 1'b1;
            rsp_err   <= ~mem_ack;
            rsp_rdata <= mem_ack ? load_data : '0;
            state     <= RESP;
          end else begin
            tmo_cnt <= tmo_cnt + 8'd1;
          end
        end
        RESP: begin
          rsp_valid <= 1'b0;
          rsp_err   <= 1'b0;
          rsp_rdata <= '0;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_load_store_unit.sv
// tb_load_store_unit: checks load_store_unit against a behavioural model.
// The model computes each response from the byte-lane rules with plain
// arithmetic. A randomized memory responder drives the ack timing.
module tb_load_store_unit;

  localparam int TMO = 16;
`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_unsigned = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic        mem_req;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_be;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = '0;

  int checks = 0;
  int errors = 0;

  load_store_unit #(.WORD_SIZE(32), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Reference value a load returns for the given size, signedness, address and memory word.
  function automatic logic [31:0] model_load(input logic [1:0] size, input logic uns,
                                             input logic [31:0] addr, input logic [31:0] word);
    int unsigned off;
    logic [31:0] v;
    off = addr % 4;
    if (size == 2'd0) begin
      v = (word >> (8 * off)) % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (size == 2'd1) begin
      v = (word >> ((off >= 2) ? 16 : 0)) % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  // One request. delay is the number of mem_req cycles without ack before the ack;
  // a delay of TMO or more means the memory never answers.
  task automatic run_txn(input logic we, input logic [1:0] size, input logic uns,
                         input logic [31:0] addr, input logic [31:0] wdata,
                         input logic [31:0] word, input int delay);
    int unsigned off;
    bit          mis;
    int          exp_cycles, exp_lat, req_cycles, c;
    logic [31:0] exp_rd, exp_wd;
    logic [3:0]  exp_be;
    logic        exp_err;
    bit          got;
    off = addr % 4;
    mis = (size == 2'd1 && (off % 2) == 1) || (size >= 2'd2 && off != 0);
    if (size == 2'd0) begin
      exp_be = 4'(1 << off);
      exp_wd = (wdata % 256) * 32'h0101_0101;
    end else if (size == 2'd1) begin
      exp_be = (off >= 2) ? 4'b1100 : 4'b0011;
      exp_wd = (wdata % 65536) * 32'h0001_0001;
    end else begin
      exp_be = 4'b1111;
      exp_wd = wdata;
    end
    if (!we) exp_be = 4'b0000;
    if (TRAP && mis) begin
      exp_cycles = 0; exp_lat = 1; exp_err = 1'b1; exp_rd = 0;
    end else if (delay >= TMO) begin
      exp_cycles = TMO; exp_lat = TMO + 1; exp_err = 1'b1; exp_rd = 0;
    end else begin
      exp_cycles = delay + 1; exp_lat = delay + 2; exp_err = 1'b0;
      exp_rd = we ? 32'd0 : model_load(size, uns, addr, word);
    end

    @(negedge clk);
    check("ready_before", {31'd0, req_ready}, 32'd1);
    req_valid = 1'b1; req_we = we; req_size = size; req_unsigned = uns;
    req_addr = addr; req_wdata = wdata;
    @(negedge clk);
    // Scramble the request fields; the unit must not sample them again.
    req_valid = 1'b0; req_we = ~we; req_size = 2'($urandom);
    req_unsigned = ~uns; req_addr = $urandom; req_wdata = $urandom;
    req_cycles = 0; c = 1; got = 1'b0;
    while (!got && c <= 40) begin
      if (mem_req) begin
        req_cycles++;
        check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
        check("mem_be", {28'd0, mem_be}, {28'd0, exp_be});
        check("mem_we", {31'd0, mem_we}, {31'd0, we});
        if (we) check("mem_wdata", mem_wdata, exp_wd);
        check("ready_busy", {31'd0, req_ready}, 32'd0);
        mem_ack   = (req_cycles == delay + 1);
        mem_rdata = mem_ack ? word : $urandom;
      end else begin
        mem_ack = 1'b0;
      end
      if (rsp_valid) begin
        got = 1'b1;
        check("rsp_latency", c, exp_lat);
        check("rsp_rdata", rsp_rdata, exp_rd);
        check("rsp_err", {31'd0, rsp_err}, {31'd0, exp_err});
        check("req_cycles", req_cycles, exp_cycles);
      end else begin
        @(negedge clk);
        c++;
      end
    end
    if (!got) check("rsp_missing", 32'd0, 32'd1);
    mem_ack = 1'b0;
    @(negedge clk);
    check("rsp_pulse", {31'd0, rsp_valid}, 32'd0);
    check("ready_after", {31'd0, req_ready}, 32'd1);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"}, {31'd0, mem_req}, 32'd0);
    check({tag, "_we"}, {31'd0, mem_we}, 32'd0);
    check({tag, "_be"}, {28'd0, mem_be}, 32'd0);
    check({tag, "_addr"}, mem_addr, 32'd0);
    check({tag, "_wdata"}, mem_wdata, 32'd0);
    check({tag, "_rsp"}, {30'd0, rsp_valid, rsp_err}, 32'd0);
    check({tag, "_rdata"}, rsp_rdata, 32'd0);
    check({tag, "_ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    bit stray;
    #1 rst = 1'b1;
    #2 check_reset_outputs("rst0");
    @(negedge clk); rst = 1'b0;

    // Directed cases from the byte-lane and timing rules.
    run_txn(1'b0, 2'd0, 1'b0, 32'h103, $urandom, 32'h80AA_BBCC, 0);
    run_txn(1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_5678, $urandom, 0);
    run_txn(1'b0, 2'd1, 1'b1, 32'h40, $urandom, 32'h0000_8001, 5);
    run_txn(1'b0, 2'd2, 1'b0, 32'h200, $urandom, $urandom, 100);
    run_txn(1'b0, 2'd2, 1'b0, 32'h06, $urandom, 32'hDEAD_BEEF, 0);
    run_txn(1'b0, 2'd0, 1'b0, 32'h11, $urandom, 32'h1234_F0FF, TMO - 1);
    run_txn(1'b1, 2'd3, 1'b0, 32'h3C, 32'hCAFE_F00D, $urandom, 2);

    // Randomized traffic, including acks on the last allowed cycle and timeouts.
    for (int i = 0; i < 60; i++) begin
      int r, d;
      r = $urandom_range(0, 9);
      d = (r < 7) ? r : (r == 7) ? TMO - 1 : (r == 8) ? TMO - 2 : TMO + 5;
      run_txn(1'($urandom), 2'($urandom), 1'($urandom), $urandom, $urandom, $urandom, d);
    end

    // Reset in the middle of an access abandons it without a response.
    @(negedge clk);
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'd2; req_addr = 32'h80;
    @(negedge clk); req_valid = 1'b0;
    @(negedge clk); @(negedge clk);
    check("mid_access_req", {31'd0, mem_req}, 32'd1);
    #2 rst = 1'b1;
    #1 check_reset_outputs("rst_mid");
    @(negedge clk); rst = 1'b0;
    stray = 1'b0;
    for (int i = 0; i < 20; i++) begin
      mem_ack = 1'($urandom);
      @(negedge clk);
      if (rsp_valid || mem_req) stray = 1'b1;
    end
    mem_ack = 1'b0;
    check("no_rsp_after_rst", {31'd0, stray}, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
